// File: rtl/tqvp_prbs_pkg.sv
// Shared encodings for the PRBS checker: FSM states, register map, CTRL bit positions, LFSR taps.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package tqvp_prbs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_ERR_LO = 4'd2;
    localparam logic [3:0] ADDR_ERR_HI = 4'd3;
    localparam logic [3:0] ADDR_BIT_LO = 4'd4;
    localparam logic [3:0] ADDR_BIT_HI = 4'd5;
    localparam logic [3:0] ADDR_EXP    = 4'd6;
    localparam logic [3:0] ADDR_THRESH = 4'd7;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_CLR      = 1;
    localparam int CTRL_RESYNC   = 2;
    localparam int CTRL_LOOPBACK = 3;
    localparam int CTRL_INJECT   = 4;

    // x^8+x^6+x^5+x^4+1 -> feedback from q[7], q[5], q[4], q[3]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] GEN_SEED  = 8'hAA;

endpackage

// File: rtl/tqvp_prbs_lfsr8.sv
// Combinational feedback bit and next state of the 8-bit PRBS LFSR.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to register q_nxt.
module tqvp_prbs_lfsr8
    import tqvp_prbs_pkg::*;
(
    input  logic [7:0] q,
    output logic       fb,
    output logic [7:0] q_nxt
);

    assign fb    = ^(q & LFSR_TAPS);
    assign q_nxt = {q[6:0], fb};

endmodule

// File: rtl/tqvp_prbs_checker.sv
// TinyQV PRBS receiver: self-seeds from ui_in, predicts each bit, counts errors/bits; TQVP_PRBS_LOOPBACK_EN adds an internal generator.
// Latency: register writes and bit events take effect on the next clk; err_pulse on uo_out 1 clk after the errored bit.
// Backpressure: none; every strobe edge is consumed, counters saturate instead of stalling.
module tqvp_prbs_checker
    import tqvp_prbs_pkg::*;
#(
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    state_t           state, state_nxt;
    logic             en, strb_q, sticky, err_pulse;
    logic [7:0]       thresh, thr_eff, q, q_seed, q_chk, consec, ctrl_rd;
    logic [2:0]       seed_cnt;
    logic [CNT_W-1:0] err_cnt, bit_cnt;
    logic [15:0]      err16, bit16;
    logic             ctrl_wr, clr_req, resync_req, run;
    logic             bit_evt, bit_val, exp_fb, mis, chk_evt, drop, lock;
    logic             unused_ui;

    assign unused_ui  = ^{ui_in[7:3], ui_in[0]};
    assign ctrl_wr    = data_write && (address == ADDR_CTRL);
    assign clr_req    = ctrl_wr && data_in[CTRL_CLR];
    assign resync_req = ctrl_wr && data_in[CTRL_RESYNC] && data_in[CTRL_EN];
    assign run        = en && !resync_req;

`ifdef TQVP_PRBS_LOOPBACK_EN
    logic       loopback, inject_pend, lb_run, g_fb;
    logic [7:0] g, g_nxt;

    tqvp_prbs_lfsr8 u_gen (.q(g), .fb(g_fb), .q_nxt(g_nxt));

    assign lb_run = en && loopback;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g           <= GEN_SEED;
            loopback    <= 1'b0;
            inject_pend <= 1'b0;
        end else begin
            if (lb_run)
                g <= g_nxt;
            if (ctrl_wr)
                loopback <= data_in[CTRL_LOOPBACK];
            if (ctrl_wr && data_in[CTRL_INJECT])
                inject_pend <= 1'b1;
            else if (lb_run)
                inject_pend <= 1'b0;
        end
    end

    assign bit_evt = lb_run || (ui_in[2] && !strb_q);
    assign bit_val = lb_run ? (g_fb ^ inject_pend) : ui_in[1];
    assign ctrl_rd = {4'b0, loopback, 2'b0, en};
`else
    assign bit_evt = ui_in[2] && !strb_q;
    assign bit_val = ui_in[1];
    assign ctrl_rd = {7'b0, en};
`endif

    tqvp_prbs_lfsr8 u_pred (.q(q), .fb(exp_fb), .q_nxt(q_chk));

    assign q_seed  = {q[6:0], bit_val};
    assign mis     = (bit_val != exp_fb);
    assign thr_eff = (thresh == 8'd0) ? 8'd1 : thresh;
    assign chk_evt = run && (state == ST_CHECK) && bit_evt;
    assign drop    = chk_evt && mis && ((consec + 8'd1) >= thr_eff);
    assign lock    = (state == ST_CHECK);

    always_comb begin
        state_nxt = state;
        if (resync_req)
            state_nxt = ST_SEED;
        else if (!en)
            state_nxt = ST_IDLE;
        else begin
            case (state)
                ST_IDLE:  state_nxt = ST_SEED;
                // an all-zero seed would lock the predictor at zero forever
                ST_SEED:  if (bit_evt && seed_cnt == 3'd7 && q_seed != 8'h00) state_nxt = ST_CHECK;
                ST_CHECK: if (drop) state_nxt = ST_SEED;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en        <= 1'b0;
            thresh    <= 8'(LOSS_THRESH);
            strb_q    <= 1'b0;
            q         <= 8'h00;
            seed_cnt  <= 3'd0;
            consec    <= 8'd0;
            err_cnt   <= '0;
            bit_cnt   <= '0;
            sticky    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            strb_q    <= ui_in[2];
            err_pulse <= chk_evt && mis;
            if (ctrl_wr)
                en <= data_in[CTRL_EN];
            if (data_write && address == ADDR_THRESH)
                thresh <= data_in;

            if (run && bit_evt && state == ST_SEED)
                q <= q_seed;
            else if (chk_evt)
                q <= q_chk;

            // 3-bit count wraps to 0 on the 8th bit, which also restarts a rejected zero seed
            if (!run || state != ST_SEED)
                seed_cnt <= 3'd0;
            else if (bit_evt)
                seed_cnt <= seed_cnt + 3'd1;

            if (clr_req || state != ST_CHECK || drop)
                consec <= 8'd0;
            else if (chk_evt)
                consec <= mis ? consec + 8'd1 : 8'd0;

            if (clr_req) begin
                err_cnt <= '0;
                bit_cnt <= '0;
                sticky  <= 1'b0;
            end else if (chk_evt) begin
                if (bit_cnt != {CNT_W{1'b1}})
                    bit_cnt <= bit_cnt + CNT_W'(1);
                if (mis) begin
                    sticky <= 1'b1;
                    if (err_cnt != {CNT_W{1'b1}})
                        err_cnt <= err_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign err16  = 16'(err_cnt);
    assign bit16  = 16'(bit_cnt);
    assign uo_out = {4'b0, err_pulse, lock, state};

    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:   data_out = ctrl_rd;
            ADDR_STATUS: data_out = {4'b0, sticky, lock, state};
            ADDR_ERR_LO: data_out = err16[7:0];
            ADDR_ERR_HI: data_out = err16[15:8];
            ADDR_BIT_LO: data_out = bit16[7:0];
            ADDR_BIT_HI: data_out = bit16[15:8];
            ADDR_EXP:    data_out = q;
            ADDR_THRESH: data_out = thresh;
            default:     data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_prbs_checker.sv
// Bench for tqvp_prbs_checker: bit-level reference model plus directed PRBS scenarios (TQVP_PRBS_LOOPBACK_EN adds loopback cases).
// A second instance with 10-bit counters exercises saturation in reasonable time.
module tb_tqvp_prbs_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [3:0] address = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] uo_out, data_out, uo_out_s, data_out_s;

    always #5 clk = ~clk;

    tqvp_prbs_checker dut (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out)
    );

    tqvp_prbs_checker #(.CNT_W(10)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out_s),
        .address(address), .data_write(data_write), .data_in(data_in), .data_out(data_out_s)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 seeding, 2 checking; counts are unbounded and clipped per instance width
    logic [1:0] m_mode   = 2'd0;
    logic [7:0] m_q      = 8'h00;
    logic [7:0] m_thr    = 8'd4;
    logic       m_en     = 1'b0;
    logic       m_sticky = 1'b0;
    logic       m_pulse  = 1'b0;
    logic       m_strb   = 1'b0;
    logic       m_on     = 1'b1;
    int         m_seed_n = 0;
    int         m_consec = 0;
    int         m_errs   = 0;
    int         m_bits   = 0;

    function automatic logic prbs_bit(input logic [7:0] v);
        return v[7] ^ v[5] ^ v[4] ^ v[3];
    endfunction

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk) begin : model
        logic evt, b, wr_ctrl, clr, resync, pred;
        int   lim;
        if (!rst_n) begin
            m_mode = 2'd0; m_q = 8'h00; m_thr = 8'd4; m_en = 1'b0; m_sticky = 1'b0;
            m_pulse = 1'b0; m_strb = 1'b0; m_seed_n = 0; m_consec = 0; m_errs = 0; m_bits = 0;
        end else begin
            evt     = ui_in[2] && !m_strb;
            m_strb  = ui_in[2];
            b       = ui_in[1];
            wr_ctrl = data_write && address == 4'd0;
            clr     = wr_ctrl && data_in[1];
            resync  = wr_ctrl && data_in[2] && data_in[0];
            m_pulse = 1'b0;
            lim     = (m_thr == 8'd0) ? 1 : int'(m_thr);
            if (resync) begin
                m_mode = 2'd1; m_seed_n = 0;
            end else if (!m_en) begin
                m_mode = 2'd0;
            end else if (m_mode == 2'd0) begin
                m_mode = 2'd1; m_seed_n = 0;
            end else if (m_mode == 2'd1 && evt) begin
                m_q = {m_q[6:0], b};
                m_seed_n++;
                if (m_seed_n == 8) begin
                    m_seed_n = 0;
                    if (m_q != 8'h00) m_mode = 2'd2;
                end
            end else if (m_mode == 2'd2 && evt) begin
                pred = prbs_bit(m_q);
                m_q  = {m_q[6:0], pred};
                m_bits++;
                if (b != pred) begin
                    m_errs++; m_sticky = 1'b1; m_pulse = 1'b1; m_consec++;
                    if (m_consec >= lim) begin
                        m_mode = 2'd1; m_seed_n = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
            if (m_mode != 2'd2) m_consec = 0;
            if (clr) begin
                m_errs = 0; m_bits = 0; m_sticky = 1'b0; m_consec = 0;
            end
            if (wr_ctrl) m_en = data_in[0];
            if (data_write && address == 4'd7) m_thr = data_in;
        end
    end

    // uo_out of both instances tracks the model every cycle
    always @(negedge clk) begin
        if (m_on) begin
            check("uo_out", {24'h0, uo_out}, {28'h0, m_pulse, m_mode == 2'd2, m_mode});
            check("uo_out_sat", {24'h0, uo_out_s}, {28'h0, m_pulse, m_mode == 2'd2, m_mode});
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] rv, rvs;
    logic       last_pulse;

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk); address = a; data_in = d; data_write = 1'b1;
        @(negedge clk); data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a);
        @(negedge clk); address = a;
        #1 rv = data_out; rvs = data_out_s;
    endtask

    task automatic check_reg(input string name, input logic [3:0] a, input logic [7:0] exp);
        rd(a);
        check(name, {24'h0, rv}, {24'h0, exp});
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk); ui_in[1] = b; ui_in[2] = 1'b1;
        @(negedge clk); ui_in[2] = 1'b0; last_pulse = uo_out[3];
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_good();
        send_bit(prbs_bit(m_q));
    endtask

    task automatic send_bad();
        send_bit(!prbs_bit(m_q));
    endtask

    task automatic check_counts(input string tag);
        logic [15:0] e, bc, es, bs;
        e  = 16'(clip(m_errs, 65535)); bc = 16'(clip(m_bits, 65535));
        es = 16'(clip(m_errs, 1023));  bs = 16'(clip(m_bits, 1023));
        rd(4'd2); check({tag, "_err_lo"}, {24'h0, rv}, {24'h0, e[7:0]});  check({tag, "_sat_err_lo"}, {24'h0, rvs}, {24'h0, es[7:0]});
        rd(4'd3); check({tag, "_err_hi"}, {24'h0, rv}, {24'h0, e[15:8]}); check({tag, "_sat_err_hi"}, {24'h0, rvs}, {24'h0, es[15:8]});
        rd(4'd4); check({tag, "_bit_lo"}, {24'h0, rv}, {24'h0, bc[7:0]}); check({tag, "_sat_bit_lo"}, {24'h0, rvs}, {24'h0, bs[7:0]});
        rd(4'd5); check({tag, "_bit_hi"}, {24'h0, rv}, {24'h0, bc[15:8]}); check({tag, "_sat_bit_hi"}, {24'h0, rvs}, {24'h0, bs[15:8]});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // reset state of the whole register map
        check("reset_uo_out", {24'h0, uo_out}, 32'h0);
        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            check($sformatf("reset_rd%0d", a), {24'h0, rv}, (a == 7) ? 32'h4 : 32'h0);
        end

        // seed with 10101010, first bit lands in q[7]
        wr(4'd0, 8'h01);
        repeat (2) @(negedge clk);
        check_reg("status_seeding", 4'd1, 8'h01);
        send_byte(8'hAA);
        check_reg("exp_after_seed", 4'd6, 8'hAA);
        check_reg("status_locked", 4'd1, 8'h06);
        check("lock_bit", {31'h0, uo_out[2]}, 32'h1);
        // 0xAA predicts 1 -> q 0x55; 0x55 also predicts 1, so a 0 is the first error
        send_bit(1'b1);
        check_reg("bit_lo_after_match", 4'd4, 8'h01);
        check_reg("err_lo_after_match", 4'd2, 8'h00);
        check_reg("exp_after_match", 4'd6, 8'h55);
        send_bit(1'b0);
        check("err_pulse_seen", {31'h0, last_pulse}, 32'h1);
        check_reg("err_lo_after_error", 4'd2, 8'h01);
        check_reg("status_sticky", 4'd1, 8'h0E);
        check_reg("exp_after_error", 4'd6, 8'hAB);

        // all-zero seed is rejected, then a real seed locks
        wr(4'd0, 8'h05);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        check_reg("status_zero_seed", 4'd1, 8'h09);
        check("no_lock_zero_seed", {31'h0, uo_out[2]}, 32'h0);
        check_reg("err_kept_resync", 4'd2, 8'h01);
        send_byte(8'hAA);
        check_reg("status_relock", 4'd1, 8'h0E);

        // loss threshold of 2
        wr(4'd7, 8'd2);
        wr(4'd0, 8'h03);
        check_reg("thresh_rd", 4'd7, 8'd2);
        check_reg("status_after_clr", 4'd1, 8'h06);
        send_bad(); send_bad();
        check_reg("status_lost", 4'd1, 8'h09);
        check_reg("err_two_bad", 4'd2, 8'h02);
        send_byte(8'h5C);
        check_reg("status_relock2", 4'd1, 8'h0E);
        send_bad(); send_good(); send_bad(); send_good();
        check_reg("status_isolated_errs", 4'd1, 8'h0E);
        check_counts("thr");

        // CLR in the same cycle as an errored bit
        @(negedge clk);
        address = 4'd0; data_in = 8'h03; data_write = 1'b1;
        ui_in[1] = !prbs_bit(m_q); ui_in[2] = 1'b1;
        @(negedge clk);
        data_write = 1'b0; ui_in[2] = 1'b0;
        check_reg("clr_race_err", 4'd2, 8'h00);
        check_reg("clr_race_bit", 4'd4, 8'h00);
        check_reg("clr_race_status", 4'd1, 8'h06);

        // saturation: 1030 errors interleaved with matches
        wr(4'd0, 8'h03);
        for (int i = 0; i < 1030; i++) begin
            send_bad(); send_good();
        end
        rd(4'd2); check("sat16_err_lo", {24'h0, rv}, 32'h06); check("sat10_err_lo", {24'h0, rvs}, 32'hFF);
        rd(4'd3); check("sat16_err_hi", {24'h0, rv}, 32'h04); check("sat10_err_hi", {24'h0, rvs}, 32'h03);
        rd(4'd4); check("sat10_bit_lo", {24'h0, rvs}, 32'hFF);
        rd(4'd5); check("sat16_bit_hi", {24'h0, rv}, 32'h08);
        check_counts("sat");

        // disabling freezes counters and returns to idle
        wr(4'd0, 8'h00);
        repeat (2) @(negedge clk);
        check_reg("status_idle", 4'd1, 8'h08);
        send_bit(1'b1); send_bit(1'b0);
        check_counts("frozen");

`ifndef TQVP_PRBS_LOOPBACK_EN
        wr(4'd0, 8'h19);
        check_reg("ctrl_no_loopback", 4'd0, 8'h01);
        wr(4'd0, 8'h00);
`endif

        // reset in the middle of seeding
        wr(4'd0, 8'h01);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        check("midreset_uo_out", {24'h0, uo_out}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            rd(4'(a));
            check($sformatf("midreset_rd%0d", a), {24'h0, rv}, (a == 7) ? 32'h4 : 32'h0);
        end

`ifdef TQVP_PRBS_LOOPBACK_EN
        begin
            int  n;
            logic locked;
            m_on = 1'b0;
            @(negedge clk); address = 4'd0; data_in = 8'h09; data_write = 1'b1;
            @(negedge clk); data_write = 1'b0;
            n = 0; locked = 1'b0;
            while (!locked && n < 12) begin
                if (uo_out[2]) locked = 1'b1;
                else begin @(negedge clk); n++; end
            end
            check("lb_lock", {31'h0, locked}, 32'h1);
            check_reg("lb_ctrl", 4'd0, 8'h09);
            repeat (1000) @(negedge clk);
            check_reg("lb_err_clean", 4'd2, 8'h00);
            wr(4'd0, 8'h19);
            repeat (20) @(negedge clk);
            check_reg("lb_err_inject", 4'd2, 8'h01);
            check("lb_lock_kept", {31'h0, uo_out[2]}, 32'h1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
